// File: rtl/bht_update_queue.sv
// Ordered FIFO of resolved conditional branches feeding the BHT update port, one write per cycle.
// Optional BHT_UPDATE_COALESCE_EN merges a resolution into the youngest entry when the PCs match.
module bht_update_queue #(
    parameter int unsigned VLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       resolved_valid_i,
    input  logic [VLEN-1:0]            resolved_pc_i,
    input  logic                       resolved_taken_i,
    output logic                       resolved_ready_o,
    // {valid, pc, taken}
    output logic [VLEN+1:0]            bht_update_o,
    input  logic                       bht_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [VLEN-1:0] pc_q [DEPTH];
    logic [DEPTH-1:0] taken_q;

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic full;
    logic out_valid;
    logic deq;
    logic alloc;
    logic upd;
    logic coalesce_hit;

    assign full      = (count_q == Full);
    assign out_valid = (count_q != '0);
    assign deq       = out_valid & bht_ready_i;

`ifdef BHT_UPDATE_COALESCE_EN
    logic [PtrW-1:0] last_ptr;

    assign last_ptr = tail_q - PtrW'(1);
    // The youngest entry is off limits only when it is also the head leaving this cycle.
    assign coalesce_hit = resolved_valid_i & out_valid
                        & (pc_q[last_ptr] == resolved_pc_i)
                        & ~((count_q == CntW'(1)) & deq);
    assign resolved_ready_o = ~full | coalesce_hit;
`else
    assign coalesce_hit     = 1'b0;
    assign resolved_ready_o = ~full;
`endif

    assign alloc = resolved_valid_i & resolved_ready_o & ~coalesce_hit & ~flush_i;
    assign upd   = coalesce_hit & ~flush_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc) tail_d = tail_q + PtrW'(1);
            if (deq)   head_d = head_q + PtrW'(1);
            unique case ({alloc, deq})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            pc_q[tail_q]    <= resolved_pc_i;
            taken_q[tail_q] <= resolved_taken_i;
        end
`ifdef BHT_UPDATE_COALESCE_EN
        if (upd) taken_q[last_ptr] <= resolved_taken_i;
`endif
    end

    assign bht_update_o = {out_valid, pc_q[head_q], taken_q[head_q]};
    assign count_o      = count_q;

    a_no_enq_full: assert property (@(posedge clk_i) disable iff (!rst_ni) alloc |-> !full);
    a_no_deq_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) deq |-> out_valid);
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= Full);
    a_upd_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni) upd |-> out_valid);

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed plus random bench for bht_update_queue against a queue-based reference model.
module tb_bht_update_queue;

    localparam int unsigned VLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            resolved_valid_i = 1'b0;
    logic [VLEN-1:0] resolved_pc_i = '0;
    logic            resolved_taken_i = 1'b0;
    logic            resolved_ready_o;
    logic [VLEN+1:0] bht_update_o;
    logic            bht_ready_i = 1'b0;
    logic [2:0]      count_o;

    int total = 0;
    int bad   = 0;

    // Model contents, oldest first, each entry {pc, taken}.
    logic [VLEN:0] q[$];

    bht_update_queue #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .resolved_valid_i (resolved_valid_i),
        .resolved_pc_i    (resolved_pc_i),
        .resolved_taken_i (resolved_taken_i),
        .resolved_ready_o (resolved_ready_o),
        .bht_update_o     (bht_update_o),
        .bht_ready_i      (bht_ready_i),
        .count_o          (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit();
`ifdef BHT_UPDATE_COALESCE_EN
        int n = q.size();
        if (!resolved_valid_i || n == 0) return 1'b0;
        if (q[n-1][VLEN:1] != resolved_pc_i) return 1'b0;
        return !(n == 1 && bht_ready_i);
`else
        return 1'b0;
`endif
    endfunction

    // Compare current outputs against the model, then fold this cycle's inputs into it.
    task automatic check_and_advance();
        int   n   = q.size();
        logic hit = model_hit();
        logic rdy = (n < DEPTH) || hit;
        chk("count", 64'(count_o), 64'(n));
        chk("valid", 64'(bht_update_o[VLEN+1]), 64'(n != 0));
        chk("ready", 64'(resolved_ready_o), 64'(rdy));
        if (n != 0) begin
            chk("head_pc", 64'(bht_update_o[VLEN:1]), 64'(q[0][VLEN:1]));
            chk("head_taken", 64'(bht_update_o[0]), 64'(q[0][0]));
        end
        if (flush_i) begin
            q.delete();
        end else begin
            if (n != 0 && bht_ready_i) void'(q.pop_front());
            if (resolved_valid_i && rdy) begin
                if (hit) q[q.size()-1][0] = resolved_taken_i;
                else q.push_back({resolved_pc_i, resolved_taken_i});
            end
        end
    endtask

    task automatic step(input logic fl, input logic v, input logic [VLEN-1:0] pc,
                        input logic tk, input logic br);
        @(negedge clk_i);
        flush_i          = fl;
        resolved_valid_i = v;
        resolved_pc_i    = pc;
        resolved_taken_i = tk;
        bht_ready_i      = br;
        #1;
        check_and_advance();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(bht_update_o[VLEN+1]), 64'd0);
        chk("rst_ready", 64'(resolved_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: single entry, visible after one edge, drained immediately
        step(0, 1, 32'h8000_0010, 1, 1);
        step(0, 0, 0, 0, 1);
        chk("t1_out", 64'(bht_update_o), 64'({1'b1, 32'h8000_0010, 1'b1}));
        step(0, 0, 0, 0, 1);
        chk("t1_empty", 64'(count_o), 64'd0);

        // 2: fill to full, fifth held off, then drain in order
        for (int i = 0; i < 4; i++) step(0, 1, 32'h1000 + 32'(16 * i), i[0], 0);
        step(0, 1, 32'h2000, 1, 0);
        chk("t2_full", 64'(count_o), 64'd4);
        chk("t2_ready", 64'(resolved_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // 3: steady state at count 2 with pointer wrap
        step(0, 1, 32'h3000, 0, 0);
        step(0, 1, 32'h3004, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 32'h3008 + 32'(4 * i), i[1], 1);
        step(0, 0, 0, 0, 0);
        chk("t3_count", 64'(count_o), 64'd2);

        // 4: flush at count 3 with a colliding enqueue
        step(0, 1, 32'h4000, 1, 0);
        step(0, 1, 32'h4004, 1, 0);
        step(0, 1, 32'h4008, 1, 1);
        step(1, 1, 32'h400c, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t4_count", 64'(count_o), 64'd0);
        chk("t4_valid", 64'(bht_update_o[VLEN+1]), 64'd0);

        // 5: same PC twice, back-pressured
        step(0, 1, 32'h100, 1, 0);
        step(0, 1, 32'h100, 0, 0);
        step(0, 0, 0, 0, 0);
`ifdef BHT_UPDATE_COALESCE_EN
        chk("t5_count", 64'(count_o), 64'd1);
        chk("t5_taken", 64'(bht_update_o[0]), 64'd0);
`else
        chk("t5_count", 64'(count_o), 64'd2);
        chk("t5_taken", 64'(bht_update_o[0]), 64'd1);
`endif
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // 6: asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) step(0, 1, 32'h5000 + 32'(4 * i), 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        @(negedge clk_i);
        bht_ready_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_valid", 64'(bht_update_o[VLEN+1]), 64'd0);
        q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Random traffic over a small PC pool to exercise coalescing and wrap
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 32'h100 + 32'(4 * $urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
